// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory access unit:
// FSM states, RISC-V load/store funct3 codes and request legality.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } dm_state_e;

  localparam logic [2:0]  F3_B      = 3'b000;
  localparam logic [2:0]  F3_H      = 3'b001;
  localparam logic [2:0]  F3_W      = 3'b010;
  localparam logic [2:0]  F3_BU     = 3'b100;
  localparam logic [2:0]  F3_HU     = 3'b101;
  localparam logic [31:0] BWEB_NONE = 32'hFFFF_FFFF;

  // Unsigned forms exist only for loads; halves and words must be naturally aligned.
  function automatic logic req_legal(input logic web, input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = web;
      F3_HU:   ok = web & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] store_bweb(input logic [2:0] funct3, input logic [1:0] off);
    logic [31:0] mask;
    case (funct3)
      F3_B:    mask = ~(32'h0000_00FF << {off, 3'b000});
      F3_H:    mask = ~(32'h0000_FFFF << {off, 3'b000});
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// Selects the addressed byte/half/word of an SRAM read word and extends it.
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] DM_DO,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = DM_DO >> {off, 3'b000};
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata = {24'h00_0000, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata = {16'h0000, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage responder: one request at a time, drives the synchronous data SRAM
// and returns aligned load data after the SRAM read latency.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_web,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              acc_err,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              DM_CEB,
  output logic              DM_WEB,
  output logic [ADDR_W-1:0] DM_A,
  output logic [31:0]       DM_DI,
  output logic [31:0]       DM_BWEB,
  input  logic [31:0]       DM_DO
);

  localparam logic [1:0] WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  dm_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              web_q, web_d;
  logic              ceb_q, ceb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0]       di_q, di_d;
  logic [31:0]       bweb_q, bweb_d;

  logic [1:0]  req_off;
  logic        legal;
  logic        accept;
  logic [31:0] load_data;
  logic        unused_addr_bits;

  assign req_off          = req_addr[1:0];
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
  assign legal            = req_legal(req_web, req_funct3, req_off);
  assign accept           = (state_q == ST_IDLE) && req_valid && legal;
  assign acc_err          = (state_q == ST_IDLE) && req_valid && !legal;
  assign stall            = accept || ((state_q == ST_ISSUE) && web_q) || (state_q == ST_WAIT);
  assign rsp_valid        = (state_q == ST_DONE);
  assign rsp_rdata        = rsp_valid ? load_data : 32'h0000_0000;

  assign DM_CEB  = ceb_q;
  assign DM_WEB  = we_q;
  assign DM_A    = a_q;
  assign DM_DI   = di_q;
  assign DM_BWEB = bweb_q;

  dm_load_align u_load_align (
    .DM_DO  (DM_DO),
    .funct3 (funct3_q),
    .off    (off_q),
    .rdata  (load_data)
  );

  // SRAM strobes are live for exactly the ISSUE cycle; address and data hold afterwards.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    web_d    = web_q;
    ceb_d    = 1'b1;
    we_d     = 1'b1;
    a_d      = a_q;
    di_d     = di_q;
    bweb_d   = BWEB_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_ISSUE;
          funct3_d = req_funct3;
          off_d    = req_off;
          web_d    = req_web;
          ceb_d    = 1'b0;
          we_d     = req_web;
          a_d      = req_addr[ADDR_W+1:2];
          di_d     = req_wdata << {req_off, 3'b000};
          bweb_d   = req_web ? BWEB_NONE : store_bweb(req_funct3, req_off);
        end
      end
      ST_ISSUE: begin
        if (!web_q) begin
          state_d = ST_IDLE;
        end else if (MEM_LAT == 1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      web_q    <= 1'b1;
      ceb_q    <= 1'b1;
      we_q     <= 1'b1;
      a_q      <= '0;
      di_q     <= 32'h0000_0000;
      bweb_q   <= BWEB_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      web_q    <= web_d;
      ceb_q    <= ceb_d;
      we_q     <= we_d;
      a_q      <= a_d;
      di_q     <= di_d;
      bweb_q   <= bweb_d;
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: two instances (read latency 1 and 3), each backed by
// a behavioural SRAM, checked against a byte-level model of memory contents.
module tb_dm_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid  [2];
  logic        req_web    [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        stall      [2];
  logic        acc_err    [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        dm_ceb     [2];
  logic        dm_web     [2];
  logic [13:0] dm_a       [2];
  logic [31:0] dm_di      [2];
  logic [31:0] dm_bweb    [2];
  logic [31:0] dm_do      [2];

  int vectors     = 0;
  int miscompares = 0;

  dm_access_unit #(.ADDR_W(14), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_web(req_web[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .stall(stall[0]), .acc_err(acc_err[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .DM_CEB(dm_ceb[0]), .DM_WEB(dm_web[0]), .DM_A(dm_a[0]), .DM_DI(dm_di[0]),
    .DM_BWEB(dm_bweb[0]), .DM_DO(dm_do[0])
  );

  dm_access_unit #(.ADDR_W(14), .MEM_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_web(req_web[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .stall(stall[1]), .acc_err(acc_err[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .DM_CEB(dm_ceb[1]), .DM_WEB(dm_web[1]), .DM_A(dm_a[1]), .DM_DI(dm_di[1]),
    .DM_BWEB(dm_bweb[1]), .DM_DO(dm_do[1])
  );

  // Behavioural SRAMs: bit-masked writes, reads delivered through a latency pipe.
  logic        mem_init;
  logic [31:0] sram    [2][256];
  logic [31:0] rd_pipe [2][4];
  logic [31:0] ref_mem [2][256];

  function automatic logic [31:0] seed_word(input int s, input int i);
    return (32'(i) * 32'h9E37_79B9) ^ ((s != 0) ? 32'h5A5A_0000 : 32'h0000_C3C3);
  endfunction

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) sram[s][i] <= seed_word(s, i);
      end else if (!dm_ceb[s] && !dm_web[s]) begin
        sram[s][dm_a[s][7:0]] <= (sram[s][dm_a[s][7:0]] & dm_bweb[s]) | (dm_di[s] & ~dm_bweb[s]);
      end
      if (!dm_ceb[s] && dm_web[s]) rd_pipe[s][0] <= sram[s][dm_a[s][7:0]];
      for (int k = 1; k < 4; k++) rd_pipe[s][k] <= rd_pipe[s][k-1];
    end
  end

  assign dm_do[0] = rd_pipe[0][0];
  assign dm_do[1] = rd_pipe[1][2];

  function automatic int access_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic web, input logic [2:0] f3, input logic [31:0] addr);
    int sz = access_size(f3);
    if (sz == 0) return 1'b0;
    if (!web && f3[2]) return 1'b0;
    return (int'(addr[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3, input int off);
    int sz = access_size(f3);
    logic [31:0] v = 32'h0;
    for (int b = 0; b < sz; b++) v[8*b +: 8] = word[8*(off+b) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int b = sz; b < 4; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on instance s, starting just after a rising edge; returns just after one.
  task automatic applyStimulus(input int s, input logic web, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bit          legal;
    bit          seen;
    int          off, sz, lat, idx, waited, stall_cycles;
    logic [31:0] exp_bweb;
    logic [31:0] word;
    off   = int'(addr[1:0]);
    sz    = access_size(f3);
    lat   = (s == 0) ? 1 : 3;
    idx   = int'(addr[9:2]);
    legal = model_legal(web, f3, addr);
    req_valid[s]  = 1'b1;
    req_web[s]    = web;
    req_funct3[s] = f3;
    req_addr[s]   = addr;
    req_wdata[s]  = wdata;
    @(negedge clk);
    checkOutput("acc_err", 32'(acc_err[s]), 32'(!legal));
    checkOutput("stall_accept", 32'(stall[s]), 32'(legal));
    @(posedge clk); #1;
    if (!legal) begin
      checkOutput("ceb_reject", 32'(dm_ceb[s]), 32'd1);
      req_valid[s] = 1'b0;
      return;
    end
    checkOutput("ceb_issue", 32'(dm_ceb[s]), 32'd0);
    checkOutput("web_issue", 32'(dm_web[s]), 32'(web));
    checkOutput("addr_issue", 32'(dm_a[s]), 32'(addr[15:2]));
    if (!web) begin
      exp_bweb = 32'hFFFF_FFFF;
      for (int b = 0; b < 4; b++)
        if (b >= off && b < off + sz) exp_bweb[8*b +: 8] = 8'h00;
      checkOutput("bweb_store", dm_bweb[s], exp_bweb);
      checkOutput("di_store", dm_di[s], wdata << (8 * off));
      checkOutput("stall_issue_store", 32'(stall[s]), 32'd0);
      for (int b = 0; b < sz; b++) ref_mem[s][idx][8*(off+b) +: 8] = wdata[8*b +: 8];
      @(posedge clk); #1;
      checkOutput("ceb_after_store", 32'(dm_ceb[s]), 32'd1);
      checkOutput("bweb_after_store", dm_bweb[s], 32'hFFFF_FFFF);
      req_valid[s] = 1'b0;
      return;
    end
    checkOutput("bweb_load", dm_bweb[s], 32'hFFFF_FFFF);
    word         = ref_mem[s][idx];
    stall_cycles = 1;
    waited       = 0;
    seen         = 1'b0;
    while (!seen && waited < 12) begin
      @(negedge clk);
      waited++;
      if (rsp_valid[s]) begin
        seen = 1'b1;
      end else begin
        if (stall[s]) stall_cycles++;
        checkOutput("rdata_idle", rsp_rdata[s], 32'h0);
      end
    end
    checkOutput("rsp_seen", 32'(seen), 32'd1);
    checkOutput("rsp_latency", 32'(waited), 32'(lat + 1));
    checkOutput("stall_cycles", 32'(stall_cycles), 32'(lat + 1));
    checkOutput("stall_done", 32'(stall[s]), 32'd0);
    checkOutput("rdata", rsp_rdata[s], model_load(word, f3, off));
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
  endtask

  initial begin
    logic        r_web;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          r_sz;
    rst      = 1'b1;
    mem_init = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]  = 1'b0;
      req_web[s]    = 1'b1;
      req_funct3[s] = 3'b000;
      req_addr[s]   = 32'h0;
      req_wdata[s]  = 32'h0;
      for (int i = 0; i < 256; i++) ref_mem[s][i] = seed_word(s, i);
    end
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("rst_ceb", 32'(dm_ceb[s]), 32'd1);
      checkOutput("rst_web", 32'(dm_web[s]), 32'd1);
      checkOutput("rst_a", 32'(dm_a[s]), 32'd0);
      checkOutput("rst_di", dm_di[s], 32'd0);
      checkOutput("rst_bweb", dm_bweb[s], 32'hFFFF_FFFF);
      checkOutput("rst_stall", 32'(stall[s]), 32'd0);
      checkOutput("rst_acc_err", 32'(acc_err[s]), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      checkOutput("rst_rdata", rsp_rdata[s], 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] directed stores and loads, latency 1");
    applyStimulus(0, 1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    applyStimulus(0, 1'b0, 3'b001, 32'h0000_0102, 32'h0000_1234);
    applyStimulus(0, 1'b0, 3'b010, 32'h0000_0100, 32'h1234_80FF);
    applyStimulus(0, 1'b1, 3'b000, 32'h0000_0101, 32'h0);
    applyStimulus(0, 1'b1, 3'b100, 32'h0000_0101, 32'h0);
    applyStimulus(0, 1'b1, 3'b010, 32'h0000_0102, 32'h0);
    applyStimulus(0, 1'b0, 3'b001, 32'h0000_0101, 32'h0000_5555);
    applyStimulus(0, 1'b1, 3'b011, 32'h0000_0100, 32'h0);

    $display("[TB] directed accesses, latency 3");
    applyStimulus(1, 1'b0, 3'b010, 32'h0000_0100, 32'h8001_BEEF);
    applyStimulus(1, 1'b1, 3'b001, 32'h0000_0102, 32'h0);

    $display("[TB] reset during the wait phase");
    req_valid[1]  = 1'b1;
    req_web[1]    = 1'b1;
    req_funct3[1] = 3'b010;
    req_addr[1]   = 32'h0000_0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("ceb_mid_rst", 32'(dm_ceb[1]), 32'd1);
    checkOutput("bweb_mid_rst", dm_bweb[1], 32'hFFFF_FFFF);
    checkOutput("a_mid_rst", 32'(dm_a[1]), 32'd0);
    checkOutput("stall_mid_rst", 32'(stall[1]), 32'd0);
    req_valid[1]  = 1'b1;
    req_funct3[1] = 3'b011;
    #1;
    checkOutput("idle_after_rst", 32'(acc_err[1]), 32'd1);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("no_rsp_after_rst", 32'(rsp_valid[1]), 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 3'b010, 32'h0000_0100, 32'h0);

    $display("[TB] randomized accesses");
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 60; n++) begin
        r_web  = 1'($urandom_range(0, 1));
        r_f3   = 3'($urandom_range(0, 7));
        r_addr = 32'($urandom_range(0, 1023));
        r_sz   = access_size(r_f3);
        if (r_sz != 0 && $urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(r_sz - 1);
        applyStimulus(s, r_web, r_f3, r_addr, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
